// File: rtl/decode_pipe.sv
// decode_pipe: WISC-SP22 decode stage with register file, write bypass, ID/EX handshake, load-use stall, halt and fetch-protocol check
module decode_pipe #(
  parameter int DATA_W = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc_inc,
  output logic              id_ready,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              wb_en,
  input  logic [2:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [4:0]        ex_opcode,
  output logic [1:0]        ex_funct,
  output logic [DATA_W-1:0] ex_r1,
  output logic [DATA_W-1:0] ex_r2,
  output logic [DATA_W-1:0] ex_imm5,
  output logic [DATA_W-1:0] ex_imm8,
  output logic [DATA_W-1:0] ex_imm11,
  output logic [DATA_W-1:0] ex_pc_inc,
  output logic [2:0]        ex_wr_reg,
  output logic              ex_reg_wrt,
  output logic              ex_mem_rd,
  output logic              ex_mem_wrt,
  output logic              ex_halt,
  output logic              err
);
  logic [DATA_W-1:0] rf_q [8];
  logic [4:0]        op;
  logic [2:0]        rs, rt, wr_reg;
  logic [DATA_W-1:0] rd1, rd2, imm5, imm8, imm11;
  logic              reg_wrt, mem_rd, mem_wrt, halt, zext, uses_src, stall, adv;
  logic              halted_q, hold_q, hold_d, err_d;
  logic [15:0]       copy_q;
  assign op = if_instr[15:11];
  assign rs = if_instr[10:8];
  assign rt = if_instr[7:5];
  // register reads, optionally forwarding a same-cycle write-back
  always_comb begin
    rd1 = (BYPASS && wb_en && wb_reg == rs) ? wb_data : rf_q[rs];
    rd2 = (BYPASS && wb_en && wb_reg == rt) ? wb_data : rf_q[rt];
  end
  // instruction decode into controls and extended immediates
  always_comb begin
    reg_wrt  = !(op[4:1] == 4'b0000 || op[4:1] == 4'b0001 || op[4:1] == 4'b0010 ||
                 op[4:2] == 3'b011 || op == 5'b10000);
    wr_reg   = (op[4:1] == 4'b0011) ? 3'd7 :
               (op[4:3] == 2'b11 && op[2:0] != 3'b000) ? if_instr[4:2] :
               (op[4:2] == 3'b010 || op[4:2] == 3'b101 || op == 5'b10000 ||
                op == 5'b10001 || op == 5'b10011) ? rt : rs;
    mem_rd   = op == 5'b10001;
    mem_wrt  = op == 5'b10000 || op == 5'b10011;
    halt     = op == 5'b00000;
    zext     = op[4:1] == 4'b0101;
    imm5     = {{(DATA_W-5){~zext & if_instr[4]}}, if_instr[4:0]};
    imm8     = {{(DATA_W-8){~zext & if_instr[7]}}, if_instr[7:0]};
    imm11    = {{(DATA_W-11){if_instr[10]}}, if_instr[10:0]};
    uses_src = !(op == 5'd0 || op == 5'd1 || op == 5'd4 || op == 5'd6 || op == 5'd24);
  end
  // load-use hazard and handshake; both source fields are compared conservatively
  always_comb begin
    stall    = if_valid & ex_valid & ex_mem_rd & uses_src & (ex_wr_reg == rs | ex_wr_reg == rt);
    adv      = ~ex_valid | ex_ready;
    id_ready = adv & ~stall & ~halted_q & ~flush;
    hold_d   = if_valid & ~id_ready & ~flush;
    err_d    = hold_q & hold_d & (if_instr != copy_q);
  end
  // register file write port
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    else if (wb_en) rf_q[wb_reg] <= wb_data;
  end
  // ID/EX payload: flush kills, accept loads, otherwise bubble or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_opcode  <= '0;
      ex_funct   <= '0;
      ex_r1      <= '0;
      ex_r2      <= '0;
      ex_imm5    <= '0;
      ex_imm8    <= '0;
      ex_imm11   <= '0;
      ex_pc_inc  <= '0;
      ex_wr_reg  <= '0;
      ex_reg_wrt <= 1'b0;
      ex_mem_rd  <= 1'b0;
      ex_mem_wrt <= 1'b0;
      ex_halt    <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (adv && id_ready) begin
      ex_valid   <= if_valid;
      ex_opcode  <= op;
      ex_funct   <= if_instr[1:0];
      ex_r1      <= rd1;
      ex_r2      <= rd2;
      ex_imm5    <= imm5;
      ex_imm8    <= imm8;
      ex_imm11   <= imm11;
      ex_pc_inc  <= if_pc_inc;
      ex_wr_reg  <= wr_reg;
      ex_reg_wrt <= reg_wrt;
      ex_mem_rd  <= mem_rd;
      ex_mem_wrt <= mem_wrt;
      ex_halt    <= halt;
    end else if (adv) begin
      ex_valid <= 1'b0;
    end
  end
  // halt latch: once a valid HALT enters ID/EX, decode stops until reset
  always_ff @(posedge clk) begin
    if (rst) halted_q <= 1'b0;
    else if (id_ready && if_valid && halt) halted_q <= 1'b1;
  end
  // fetch must hold its instruction while id_ready is low; a change is a sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 1'b0;
      copy_q <= '0;
      err    <= 1'b0;
    end else begin
      hold_q <= hold_d;
      if (hold_d) copy_q <= if_instr;
      err <= err | err_d;
    end
  end
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: vector table plus scoreboard for decode_pipe, with a BYPASS=0 twin for the bypass check
module tb_decode_pipe;
  logic        clk = 1'b0, rst, if_valid, flush, ex_ready, wb_en;
  logic [15:0] if_instr, if_pc_inc, wb_data;
  logic [2:0]  wb_reg;
  logic        id_ready, ex_valid, ex_reg_wrt, ex_mem_rd, ex_mem_wrt, ex_halt, err;
  logic [4:0]  ex_opcode;
  logic [1:0]  ex_funct;
  logic [2:0]  ex_wr_reg;
  logic [15:0] ex_r1, ex_r2, ex_imm5, ex_imm8, ex_imm11, ex_pc_inc;
  logic        b_id_ready, b_ex_valid, b_ex_reg_wrt, b_ex_mem_rd, b_ex_mem_wrt, b_ex_halt, b_err;
  logic [4:0]  b_ex_opcode;
  logic [1:0]  b_ex_funct;
  logic [2:0]  b_ex_wr_reg;
  logic [15:0] b_ex_r1, b_ex_r2, b_ex_imm5, b_ex_imm8, b_ex_imm11, b_ex_pc_inc;

  decode_pipe #(.DATA_W(16), .BYPASS(1'b1)) u0 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc_inc(if_pc_inc),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_imm5(ex_imm5), .ex_imm8(ex_imm8), .ex_imm11(ex_imm11),
    .ex_pc_inc(ex_pc_inc), .ex_wr_reg(ex_wr_reg), .ex_reg_wrt(ex_reg_wrt), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wrt(ex_mem_wrt), .ex_halt(ex_halt), .err(err));

  decode_pipe #(.DATA_W(16), .BYPASS(1'b0)) u1 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc_inc(if_pc_inc),
    .id_ready(b_id_ready), .flush(flush), .ex_ready(ex_ready), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .ex_valid(b_ex_valid), .ex_opcode(b_ex_opcode), .ex_funct(b_ex_funct),
    .ex_r1(b_ex_r1), .ex_r2(b_ex_r2), .ex_imm5(b_ex_imm5), .ex_imm8(b_ex_imm8), .ex_imm11(b_ex_imm11),
    .ex_pc_inc(b_ex_pc_inc), .ex_wr_reg(b_ex_wr_reg), .ex_reg_wrt(b_ex_reg_wrt), .ex_mem_rd(b_ex_mem_rd),
    .ex_mem_wrt(b_ex_mem_wrt), .ex_halt(b_ex_halt), .err(b_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  wr;
    logic        rw, mr, mw, h;
    logic [15:0] i5, i8, i11;
  } vec_t;
  typedef struct {
    vec_t        v;
    logic [15:0] pc, r1, r2;
  } exp_t;

  vec_t        tbl[12];
  vec_t        v_add, v_byp, v_halt, cv;
  exp_t        sbq[$];
  exp_t        cur;
  bit          pend, acc;
  logic [15:0] regs[8];
  logic [15:0] old;
  int          nvec = 0, nerr = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  // one clock: record acceptance, update the register model, then check ID/EX
  task automatic step();
    exp_t e;
    #1;
    if (!ex_valid || ex_ready) pend = 1'b0;
    acc = if_valid && id_ready;
    if (acc) begin
      e.v  = cv;
      e.pc = if_pc_inc;
      e.r1 = (wb_en && wb_reg == if_instr[10:8]) ? wb_data : regs[if_instr[10:8]];
      e.r2 = (wb_en && wb_reg == if_instr[7:5]) ? wb_data : regs[if_instr[7:5]];
      sbq.push_back(e);
    end
    if (wb_en) regs[wb_reg] = wb_data;
    @(posedge clk);
    #1;
    if (!ex_valid) pend = 1'b0;
    else begin
      if (!pend) begin
        chk("sb_has_entry", sbq.size() > 0, 1);
        if (sbq.size() > 0) cur = sbq.pop_front();
        pend = 1'b1;
      end
      chk("opcode_funct", {ex_opcode, ex_funct}, {cur.v.instr[15:11], cur.v.instr[1:0]});
      chk("r1", ex_r1, cur.r1);
      chk("r2", ex_r2, cur.r2);
      chk("imm5", ex_imm5, cur.v.i5);
      chk("imm8", ex_imm8, cur.v.i8);
      chk("imm11", ex_imm11, cur.v.i11);
      chk("pc_inc", ex_pc_inc, cur.pc);
      chk("ctl", {ex_wr_reg, ex_reg_wrt, ex_mem_rd, ex_mem_wrt, ex_halt},
          {cur.v.wr, cur.v.rw, cur.v.mr, cur.v.mw, cur.v.h});
    end
  endtask

  task automatic drive(input vec_t v, input logic [15:0] pc);
    cv = v;
    if_valid = 1'b1;
    if_instr = v.instr;
    if_pc_inc = pc;
  endtask

  task automatic reset();
    rst = 1'b1;
    if_valid = 1'b0;
    flush = 1'b0;
    wb_en = 1'b0;
    ex_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    sbq.delete();
    pend = 1'b0;
  endtask

  task automatic load_use(input int hold, input int exp_stall);
    int st = 0, bub = 0;
    ex_ready = 1'b1;
    drive(tbl[3], 16'h0300);
    step();
    drive(v_add, 16'h0302);
    for (int k = 0; k < 10; k++) begin
      ex_ready = (k >= hold);
      step();
      if (acc) break;
      st++;
      if (!ex_valid) bub++;
    end
    chk("stall_cycles", st, exp_stall);
    chk("bubbles", bub, 1);
    chk("dep_issued", ex_valid, 1);
    if_valid = 1'b0;
    ex_ready = 1'b1;
    step();
  endtask

  initial begin
    tbl[0]  = '{16'h423D, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFD, 16'h003D, 16'h023D};
    tbl[1]  = '{16'h539F, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h001F, 16'h009F, 16'h039F};
    tbl[2]  = '{16'h85C2, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 16'hFFC2, 16'hFDC2};
    tbl[3]  = '{16'h8960, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0060, 16'h0160};
    tbl[4]  = '{16'h37FE, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE, 16'hFFFE, 16'hFFFE};
    tbl[5]  = '{16'hDC44, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0044, 16'hFC44};
    tbl[6]  = '{16'h6280, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFF80, 16'h0280};
    tbl[7]  = '{16'hC5FF, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFDFF};
    tbl[8]  = '{16'h9E23, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0023, 16'hFE23};
    tbl[9]  = '{16'h5F15, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0015, 16'h0015, 16'hFF15};
    tbl[10] = '{16'h0800, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    tbl[11] = '{16'h9381, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'hFF81, 16'h0381};
    v_add   = '{16'hDB50, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFF0, 16'h0050, 16'h0350};
    v_byp   = '{16'h4541, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0041, 16'hFD41};
    v_halt  = '{16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) regs[i] = '0;
    pend = 1'b0;
    rst = 1'b1;
    flush = 1'b0;
    ex_ready = 1'b1;
    wb_en = 1'b0;
    wb_reg = '0;
    wb_data = '0;
    drive(tbl[0], 16'h0100);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_ex_halt", ex_halt, 0);
    chk("rst_pc_inc", ex_pc_inc, 0);
    chk("rst_id_ready", id_ready, 1);
    rst = 1'b0;
    step();
    chk("first_latency", ex_valid, 1);
    if_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wb_en = 1'b1;
      wb_reg = 3'(i);
      wb_data = 16'(16'hA000 + 16'h0111 * i);
      step();
    end
    wb_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i], 16'(16'h0200 + 2 * i));
      step();
      chk($sformatf("accept_%0d", i), acc, 1);
      chk($sformatf("latency_%0d", i), ex_valid, 1);
    end
    if_valid = 1'b0;
    step();
    chk("table_drained", sbq.size(), 0);
    load_use(0, 1);
    load_use(2, 3);
    drive(v_byp, 16'h0400);
    wb_en = 1'b1;
    wb_reg = 3'd5;
    wb_data = 16'hBEEF;
    old = regs[5];
    step();
    wb_en = 1'b0;
    chk("bypass_on_r1", ex_r1, 16'hBEEF);
    chk("bypass_off_r1", b_ex_r1, old);
    if_valid = 1'b0;
    step();
    drive(tbl[0], 16'h0500);
    step();
    if_instr = 16'h37FE;
    flush = 1'b1;
    ex_ready = 1'b0;
    step();
    chk("flush_id_ready", acc, 0);
    chk("flush_kill", ex_valid, 0);
    flush = 1'b0;
    ex_ready = 1'b1;
    if_valid = 1'b0;
    step();
    chk("flush_no_jal", ex_valid, 0);
    drive(tbl[3], 16'h0510);
    step();
    drive(v_add, 16'h0512);
    flush = 1'b1;
    step();
    chk("flush_stall_bubble", ex_valid, 0);
    flush = 1'b0;
    if_valid = 1'b0;
    step();
    drive(v_halt, 16'h0600);
    step();
    chk("halt_issued", ex_valid && ex_halt, 1);
    drive(tbl[10], 16'h0602);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("halted_id_ready", acc, 0);
      chk("halted_bubble", ex_valid, 0);
    end
    chk("halted_no_err", err, 0);
    reset();
    drive(tbl[10], 16'h0700);
    #1;
    chk("rst_unhalts", id_ready, 1);
    step();
    drive(tbl[3], 16'h0710);
    step();
    drive(v_add, 16'h0712);
    ex_ready = 1'b0;
    step();
    chk("proto_hold_ok", err, 0);
    if_instr = 16'hDB51;
    step();
    chk("proto_err", err, 1);
    ex_ready = 1'b1;
    if_valid = 1'b0;
    repeat (3) step();
    chk("proto_sticky", err, 1);
    chk("final_drained", sbq.size(), 0);
    reset();
    chk("proto_rst_clears", err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
